// File: rtl/serdes_frame_decryptor.sv
// Receive-side frame decryptor: hunts a sync word in an MSB-first bit stream, XOR-decrypts a
// fixed-length payload with per-byte key slices, checks a trailing checksum and buffers plaintext in a FWFT FIFO.
module serdes_frame_decryptor #(
  parameter logic [7:0] SYNC_WORD     = 8'hA5,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         FIFO_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [127:0] key,
  input  logic         ser_valid,
  input  logic         ser_bit,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_done,
  output logic         frame_err,
  output logic         overflow,
  output logic         busy
);

  localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW       = AW + 1;
  localparam logic [3:0]    LAST_IDX = 4'(PAYLOAD_BYTES - 1);
  localparam logic [3:0]    CHK_IDX  = 4'(PAYLOAD_BYTES);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  function automatic logic [7:0] key_slice(input logic [127:0] k, input logic [3:0] idx);
    return k[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [3:0] fill_sat_inc(input logic [3:0] v);
    return (v >= 4'd8) ? 4'd8 : v + 4'd1;
  endfunction

  state_t      state_q, state_d;
  logic [6:0]  win_q, win_d;
  logic [3:0]  fill_q, fill_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        bit_stb;
  logic [7:0]  cbyte;
  logic [7:0]  plain;
  logic [7:0]  rx;
  logic        byte_vld;
  logic [7:0]  byte_data;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          pop;
  logic          push_ok;

  assign bit_stb = ena & ser_valid;
  // Only the low seven window bits are ever needed: the eighth comes straight from ser_bit.
  assign cbyte   = {win_q, ser_bit};
  assign plain   = cbyte ^ key_slice(key, byte_idx_q);
  assign rx      = cbyte ^ key_slice(key, CHK_IDX);

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    fill_d     = fill_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    byte_vld   = 1'b0;
    byte_data  = plain;
    if (bit_stb) begin
      win_d = cbyte[6:0];
      case (state_q)
        HUNT: begin
          fill_d = fill_sat_inc(fill_q);
          if ((fill_q >= 4'd7) && (cbyte == SYNC_WORD)) begin
            state_d    = PAYLOAD;
            bit_cnt_d  = 3'd0;
            byte_idx_d = 4'd0;
            csum_d     = 8'h00;
          end
        end
        PAYLOAD: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            csum_d     = csum_q ^ plain;
            byte_vld   = 1'b1;
            byte_idx_d = byte_idx_q + 4'd1;
            if (byte_idx_q == LAST_IDX) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            done_d  = 1'b1;
            err_d   = (rx != csum_q);
            state_d = HUNT;
            fill_d  = 4'd0;
          end
        end
        default: begin
          state_d = HUNT;
          fill_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      win_q      <= 7'd0;
      fill_q     <= 4'd0;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      csum_q     <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      fill_q     <= fill_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Output FIFO: a push into a full FIFO is still accepted when the head leaves on the same edge.
  assign pop     = out_valid & out_ready;
  assign push_ok = byte_vld & ((count_q < FULL_CNT) | pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (byte_vld && !push_ok) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= byte_data;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != HUNT);

endmodule

// File: tb/tb_serdes_frame_decryptor.sv
// Scoreboard bench for serdes_frame_decryptor: a queue-based stream model predicts plaintext,
// frame results and FIFO drops; a negedge monitor compares whatever the DUT presents.
module tb_serdes_frame_decryptor;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         P    = 4;
  localparam int         D    = 4;
  localparam logic [127:0] KEY0 = 128'h0F0E0D0C0B0A09080706050403020100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [127:0] key;
  logic         ser_valid;
  logic         ser_bit;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         frame_done;
  logic         frame_err;
  logic         overflow;
  logic         busy;

  always #5 clk = ~clk;

  serdes_frame_decryptor #(
    .SYNC_WORD    (SYNC),
    .PAYLOAD_BYTES(P),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .key       (key),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  bit         frm_q[$];
  logic [7:0] got_q[$];
  bit         exp_ovf  = 1'b0;
  bit         exp_busy = 1'b0;
  int         n_done   = 0;
  bit         last_err = 1'b0;
  bit         mon_en   = 1'b0;
  logic [7:0] mon_e;
  bit         mon_fe;

  bit         m_sync = 1'b0;
  bit         hunt_bits[$];
  logic [7:0] m_byte = 8'h00;
  int         m_nbits = 0;
  int         m_bytes = 0;
  logic [7:0] m_csum = 8'h00;

  bit         pend_push = 1'b0;
  bit         pend_drop = 1'b0;
  bit         pend_done = 1'b0;
  bit         pend_err  = 1'b0;
  bit         pend_rst  = 1'b0;
  logic [7:0] pend_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] kslice(input int idx);
    return key[8*idx +: 8];
  endfunction

  task automatic model_clear();
    m_sync  = 1'b0;
    hunt_bits.delete();
    m_nbits = 0;
    m_bytes = 0;
    m_csum  = 8'h00;
  endtask

  // Stream model: last 8 bits seen since hunting began, then bytes counted off the frame.
  task automatic model_bit(input bit b, input bit r);
    logic [7:0] w;
    logic [7:0] plain;
    if (!m_sync) begin
      hunt_bits.push_back(b);
      if (hunt_bits.size() > 8) void'(hunt_bits.pop_front());
      w = 8'h00;
      foreach (hunt_bits[i]) w = {w[6:0], hunt_bits[i]};
      if (hunt_bits.size() == 8 && w == SYNC) begin
        m_sync  = 1'b1;
        m_nbits = 0;
        m_bytes = 0;
        m_csum  = 8'h00;
      end
    end else begin
      m_byte = {m_byte[6:0], b};
      m_nbits++;
      if (m_nbits == 8) begin
        m_nbits = 0;
        if (m_bytes < P) begin
          plain  = m_byte ^ kslice(m_bytes);
          m_csum = m_csum ^ plain;
          m_bytes++;
          if (exp_q.size() < D || (exp_q.size() > 0 && r)) begin
            pend_push = 1'b1;
            pend_byte = plain;
          end else begin
            pend_drop = 1'b1;
          end
        end else begin
          pend_done = 1'b1;
          pend_err  = ((m_byte ^ kslice(P)) != m_csum);
          m_sync    = 1'b0;
          hunt_bits.delete();
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (pend_rst) begin
      exp_q.delete();
      frm_q.delete();
      exp_ovf  = 1'b0;
      pend_rst = 1'b0;
    end
    if (pend_push) exp_q.push_back(pend_byte);
    if (pend_drop) exp_ovf = 1'b1;
    if (pend_done) frm_q.push_back(pend_err);
    pend_push = 1'b0;
    pend_drop = 1'b0;
    pend_done = 1'b0;
    exp_busy  = m_sync;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (!out_valid) begin
        chk("out_data_empty", 32'(out_data), 32'd0);
      end else if (out_ready && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e));
        got_q.push_back(out_data);
      end
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("frame_done", 32'(frame_done), 32'(frm_q.size() != 0));
      if (frm_q.size() != 0) begin
        mon_fe = frm_q.pop_front();
        chk("frame_err", 32'(frame_err), 32'(mon_fe));
        n_done++;
        last_err = frame_err;
      end else begin
        chk("frame_err_idle", 32'(frame_err), 32'd0);
      end
    end
  end

  task automatic drive(input bit e, input bit v, input bit b, input bit r);
    @(posedge clk);
    #2;
    ena       = e;
    ser_valid = v;
    ser_bit   = b;
    out_ready = r;
    if (e && v) model_bit(b, r);
  endtask

  function automatic bit pick_r(input int mode);
    return (mode == 2) ? 1'($urandom) : (mode == 1);
  endfunction

  task automatic idle(input int n, input int rmode);
    repeat (n) drive(1'b1, 1'b0, 1'($urandom), pick_r(rmode));
  endtask

  task automatic send_byte(input logic [7:0] c, input int rmode, input bit gappy);
    int n;
    for (int i = 7; i >= 0; i--) begin
      if (gappy) begin
        n = $urandom_range(0, 2);
        repeat (n) begin
          if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b1, 1'($urandom), pick_r(rmode));
          else                           drive(1'b1, 1'b0, 1'($urandom), pick_r(rmode));
        end
      end
      drive(1'b1, 1'b1, c[i], pick_r(rmode));
    end
  endtask

  task automatic send_byte_pulse(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) drive(1'b1, 1'b1, c[i], (i == 0));
  endtask

  task automatic send_frame(input logic [7:0] f[6], input int rmode, input bit gappy);
    for (int j = 0; j < 6; j++) send_byte(f[j], rmode, gappy);
  endtask

  task automatic send_noise(input int rmode, input bit gappy);
    drive(1'b1, 1'b1, 1'b1, pick_r(rmode));
    if (gappy) drive(1'b0, 1'b1, 1'b0, pick_r(rmode));
    drive(1'b1, 1'b1, 1'b0, pick_r(rmode));
    if (gappy) drive(1'b1, 1'b0, 1'b1, pick_r(rmode));
    drive(1'b1, 1'b1, 1'b1, pick_r(rmode));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    ser_valid = 1'b0;
    out_ready = 1'b0;
    model_clear();
    pend_rst  = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_got(input string name);
    logic [7:0] want[4];
    want = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk({name, "_count"}, 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) chk({name, "_byte"}, 32'(got_q[i]), 32'(want[i]));
    end
    got_q.delete();
  endtask

  logic [7:0] clean_f[6];
  logic [7:0] bad_f[6];
  logic [7:0] rf[6];
  int         done0;

  initial begin
    clean_f   = '{8'hA5, 8'h11, 8'h23, 8'h31, 8'h47, 8'h40};
    bad_f     = '{8'hA5, 8'h11, 8'h23, 8'h31, 8'h47, 8'h41};
    rst_n     = 1'b0;
    ena       = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    out_ready = 1'b0;
    key       = KEY0;
    model_clear();

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // clean decode
    done0 = n_done;
    send_noise(1, 1'b0);
    send_frame(clean_f, 1, 1'b0);
    idle(6, 1);
    check_got("clean");
    chk("clean_frames", 32'(n_done - done0), 32'd1);
    chk("clean_err", 32'(last_err), 32'd0);
    chk("clean_busy", 32'(busy), 32'd0);

    // checksum error
    done0 = n_done;
    send_noise(1, 1'b0);
    send_frame(bad_f, 1, 1'b0);
    idle(6, 1);
    check_got("bad");
    chk("bad_frames", 32'(n_done - done0), 32'd1);
    chk("bad_err", 32'(last_err), 32'd1);

    // backpressure and overflow
    send_frame(clean_f, 0, 1'b0);
    idle(2, 0);
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    chk("bp_no_ovf", 32'(overflow), 32'd0);
    send_frame(clean_f, 0, 1'b0);
    idle(2, 0);
    chk("bp_ovf", 32'(overflow), 32'd1);
    idle(8, 1);
    check_got("bp_drain");
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("bp_ovf_cleared", 32'(overflow), 32'd0);

    // push and pop on the same edge while full
    send_frame(clean_f, 0, 1'b0);
    idle(2, 0);
    send_byte(8'hA5, 0, 1'b0);
    for (int j = 1; j <= 4; j++) send_byte_pulse(clean_f[j]);
    send_byte(8'h40, 0, 1'b0);
    idle(2, 0);
    chk("sim_no_ovf", 32'(overflow), 32'd0);
    chk("sim_full_valid", 32'(out_valid), 32'd1);
    check_got("sim_popped");
    idle(8, 1);
    check_got("sim_drain");

    // gaps and ena low with junk bits
    done0 = n_done;
    send_noise(1, 1'b1);
    send_frame(clean_f, 1, 1'b1);
    idle(6, 1);
    check_got("gaps");
    chk("gaps_err", 32'(last_err), 32'd0);
    chk("gaps_frames", 32'(n_done - done0), 32'd1);

    // reset mid-frame
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h23, 0, 1'b0);
    do_reset();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    got_q.delete();
    done0 = n_done;
    send_frame(clean_f, 1, 1'b0);
    idle(6, 1);
    check_got("midrst_clean");
    chk("midrst_err", 32'(last_err), 32'd0);
    chk("midrst_frames", 32'(n_done - done0), 32'd1);

    // randomized frames, key, noise, gaps and consumer stalls
    do_reset();
    key = {$urandom, $urandom, $urandom, $urandom};
    for (int fr = 0; fr < 40; fr++) begin
      logic [7:0] cs;
      int nn;
      nn = $urandom_range(0, 12);
      repeat (nn) drive(1'b1, 1'b1, 1'($urandom), pick_r(2));
      rf[0] = SYNC;
      cs    = 8'h00;
      for (int j = 1; j <= P; j++) begin
        rf[j] = 8'($urandom);
        cs    = cs ^ rf[j] ^ kslice(j - 1);
      end
      rf[5] = cs ^ kslice(P);
      if ($urandom_range(0, 3) == 0) rf[5] = rf[5] ^ 8'($urandom_range(1, 255));
      send_frame(rf, 2, 1'($urandom));
    end
    idle(40, 1);
    chk("rand_fifo_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_frames_seen", 32'(frm_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serdes_frame_decryptor.md
Name: serdes_frame_decryptor

Overview:
- Receive-side stage directly downstream of the secure SerDes encryptor core.
- Consumes its MSB-first serial ciphertext, hunts for a sync word, deserializes a fixed-length payload and XOR-decrypts it with a per-byte rolling key slice.
- Verifies a trailing checksum byte.
- Delivers plaintext bytes through a small first-word-fall-through FIFO with a valid/ready handshake.

Parameters:
SYNC_WORD, 8'hA5, frame sync pattern, sent in clear, MSB first
PAYLOAD_BYTES, 4, payload bytes per frame, legal range 1..15
FIFO_DEPTH, 4, output FIFO entries, power of two, 2..16

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
ena  input  1  gates bit sampling; FIFO pop still works when low
key  input  128  decryption key; byte slice k is key[8k+7:8k]
ser_valid  input  1  ser_bit is sampled this cycle (when ena=1)
ser_bit  input  1  serial ciphertext bit, MSB first
out_data  output  8  plaintext byte at FIFO head
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts out_data this cycle
frame_done  output  1  one-cycle pulse when checksum byte completes
frame_err  output  1  one-cycle pulse, coincident with frame_done, on checksum mismatch
overflow  output  1  sticky; a byte was dropped because the FIFO was full
busy  output  1  high when state != HUNT

Behaviour:
- Bit strobe: bit_stb = ena & ser_valid. Nothing in the receive path advances without bit_stb.
- Reset (rst_n=0 at clk edge):
  - State = HUNT; all counters, window, checksum and FIFO pointers/count cleared.
  - Outputs: out_valid=0, out_data=0, frame_done=0, frame_err=0, overflow=0, busy=0.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Shift register: on bit_stb, sr <= {sr[6:0], ser_bit}.
- State HUNT:
  - fill counter saturates at 8 and is cleared on entry to HUNT.
  - On bit_stb, if fill >= 7 and {sr[6:0], ser_bit} == SYNC_WORD: go to PAYLOAD, bit_cnt=0, byte_idx=0, csum=0.
  - Stale bits from a prior frame can never form a match.
- State PAYLOAD:
  - bit_cnt increments per bit_stb.
  - On the 8th bit (bit_cnt==7): cbyte = {sr[6:0], ser_bit}; plain = cbyte ^ key slice[byte_idx]; csum ^= plain; push plain to FIFO; byte_idx++.
  - When byte_idx reaches PAYLOAD_BYTES, go to CHECK.
- State CHECK:
  - Collect 8 bits. rx = cbyte ^ key slice[PAYLOAD_BYTES].
  - Next cycle: frame_done=1, frame_err=(rx != csum); return to HUNT (fill=0).
  - The checksum byte is never pushed to the FIFO.
- Key: sampled combinationally at each byte completion and must be stable for the whole frame.
- FIFO (first-word fall-through):
  - out_valid = count != 0; out_data = head entry (0 when empty).
  - Pop occurs when out_valid & out_ready.
  - Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop: accepted, count unchanged).
  - Otherwise the byte is dropped, overflow <= 1 until reset, and FIFO contents are unchanged. The checksum still includes dropped bytes.
  - Push latency: a byte completed on the edge sampling its 8th bit is visible on out_data/out_valid after that edge (1 cycle).
  - Pointers wrap modulo FIFO_DEPTH.
- Back-to-back frames: a new sync may start on the first bit_stb after frame_done; HUNT requires 8 fresh bits.

Test Plan:
- Clean decode:
  - Setup: key=128'h0F0E0D0C0B0A09080706050403020100, out_ready=1.
  - Stimulus: bits 1,0,1 (noise), then bytes A5,11,23,31,47,40.
  - Required: out_data sequence 11,22,33,44; frame_done pulse with frame_err=0; busy low afterwards.
- Checksum error: same stream with last byte 41 -> four bytes 11,22,33,44 still delivered; frame_done=1 and frame_err=1 in the same cycle.
- Backpressure/overflow:
  - Stimulus: out_ready=0; send one frame (FIFO full, overflow=0), then a second frame.
  - Required: all second-frame payload bytes dropped, overflow=1 sticky.
  - Then raise out_ready: exactly 11,22,33,44 drain, out_valid=0.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full; pulse out_ready for one cycle exactly on a byte-completion edge.
  - Required: count stays 4, no overflow, new byte appears at tail.
- Gaps/ena: interleave ser_valid=0 cycles and ena=0 cycles carrying junk ser_bit values -> decode identical to the clean decode scenario.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 for one edge after two payload bytes.
  - Required: out_valid=0, busy=0, overflow=0.
  - Then a full clean frame decodes to 11,22,33,44 with frame_err=0.
